// File: rtl/blinkt_frame_sched_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | blinkt_pkg : shared states, frame words and pixel packing helper  |
// | Revision   : 1.0                                                  |
// +-------------------------------------------------------------------+
package blinkt_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_PIXEL = 2'd2;
  localparam logic [1:0] ST_END   = 2'd3;

  localparam logic [31:0] START_WORD = 32'h0000_0000;
  localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;
  localparam logic [2:0]  LED_HDR    = 3'b111;

  typedef struct packed {
    logic [2:0] rsvd;
    logic [4:0] bri;
    logic [7:0] blue;
    logic [7:0] green;
    logic [7:0] red;
  } pixel_t;

  function automatic logic [31:0] pack_pixel(input logic [4:0] bri, input logic [7:0] b,
                                             input logic [7:0] g, input logic [7:0] r);
    return {LED_HDR, bri, b, g, r};
  endfunction

endpackage
`default_nettype wire

// File: rtl/blinkt_frame_sched_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | blinkt_frame_sched_if : AXIS word channel towards the LED shifter |
// | Revision              : 1.0                                       |
// +-------------------------------------------------------------------+
interface blinkt_frame_sched_if;
  logic [31:0] m_axis_data;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport master (output m_axis_data, output m_axis_tvalid, input m_axis_tready);
  modport slave  (input m_axis_data, input m_axis_tvalid, output m_axis_tready);
endinterface
`default_nettype wire

// File: rtl/blinkt_frame_sched_refresh_timer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | blinkt_refresh_timer : free-running divider, one-cycle expiry     |
// | Revision             : 1.0                                        |
// +-------------------------------------------------------------------+
module blinkt_refresh_timer #(
  parameter int unsigned REFRESH_DIV = 1_000_000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((REFRESH_DIV == 0) ? 0 : REFRESH_DIV - 1);
  localparam logic       ENABLED = (REFRESH_DIV != 0);

  logic [CNT_W-1:0] count_q, count_d;
  logic             active;

  assign active   = i_en & ENABLED;
  assign o_expire = active && (count_q == LAST);

  // Counter sits at zero whenever the timer is not running.
  always_comb begin
    count_d = '0;
    if (active && !o_expire) count_d = count_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) count_q <= '0;
    else            count_q <= count_d;
  end

endmodule
`default_nettype wire

// File: rtl/blinkt_frame_sched.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | blinkt_frame_sched : double-buffered APA102 frame sequencer (AXIS)|
// | Revision           : 1.0                                          |
// +-------------------------------------------------------------------+
module blinkt_frame_sched
  import blinkt_pkg::*;
#(
  parameter  int unsigned NUM_LEDS    = 8,
  parameter  int unsigned REFRESH_DIV = 1_000_000,
  parameter  int unsigned END_WORDS   = 1,
  localparam int unsigned ADDR_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [31:0]       i_wr_data,
  input  logic              i_refresh,
  input  logic              i_auto_en,
  blinkt_frame_sched_if.master m_axis,
  output logic              o_busy,
  output logic              o_frame_done
);

  localparam int unsigned CNT_W = (END_WORDS > 1) ? $clog2(END_WORDS) : 1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              tvalid_q, tvalid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  pixel_t            pend_bank_q [NUM_LEDS];
  pixel_t            pend_bank_d [NUM_LEDS];
  pixel_t            act_bank_q  [NUM_LEDS];
  pixel_t            act_bank_d  [NUM_LEDS];

  logic        timer_expire;
  logic        handshake;
  logic        refresh_req;
  logic [31:0] data_w;
  pixel_t      cur_pix;

  blinkt_refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (i_auto_en),
    .o_expire  (timer_expire)
  );

  assign handshake   = tvalid_q & m_axis.m_axis_tready;
  assign refresh_req = pend_q | i_refresh | timer_expire;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    tvalid_d    = tvalid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pend_d      = pend_q | i_refresh | timer_expire;
    pend_bank_d = pend_bank_q;
    act_bank_d  = act_bank_q;

    if (i_wr_en && (32'(i_wr_addr) < NUM_LEDS))
      pend_bank_d[i_wr_addr] = pixel_t'(i_wr_data);

    case (state_q)
      ST_IDLE: begin
        // Snapshot uses the registered pending bank, so a same-cycle write waits a frame.
        if (refresh_req) begin
          act_bank_d = pend_bank_q;
          pend_d     = 1'b0;
          state_d    = ST_START;
          tvalid_d   = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_START: begin
        if (handshake) begin
          state_d = ST_PIXEL;
          idx_d   = '0;
        end
      end
      ST_PIXEL: begin
        if (handshake) begin
          if (idx_q == ADDR_W'(NUM_LEDS - 1)) begin
            state_d = ST_END;
            cnt_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_END: begin
        if (handshake) begin
          if (cnt_q == CNT_W'(END_WORDS - 1)) begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Output word is a pure function of held state, so it cannot move during a stall.
  always_comb begin
    cur_pix = act_bank_q[idx_q];
    data_w  = START_WORD;
    case (state_q)
      ST_PIXEL: data_w = pack_pixel(cur_pix.bri, cur_pix.blue, cur_pix.green, cur_pix.red);
      ST_END:   data_w = END_WORD;
      default:  data_w = START_WORD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < int'(NUM_LEDS); i++) begin
        pend_bank_q[i] <= '0;
        act_bank_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      tvalid_q    <= tvalid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pend_bank_q <= pend_bank_d;
      act_bank_q  <= act_bank_d;
    end
  end

  assign m_axis.m_axis_data   = data_w;
  assign m_axis.m_axis_tvalid = tvalid_q;
  assign o_busy               = busy_q;
  assign o_frame_done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_blinkt_frame_sched.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_blinkt_frame_sched : directed frame-sequence bench             |
// | Revision              : 1.0                                       |
// +-------------------------------------------------------------------+
module tb_blinkt_frame_sched;

  localparam int FW = 10;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_wr_en;
  logic [2:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic        i_refresh;
  logic        i_auto_en;
  logic        o_busy;
  logic        o_frame_done;

  blinkt_frame_sched_if axis_if ();

  blinkt_frame_sched #(
    .NUM_LEDS    (8),
    .REFRESH_DIV (100),
    .END_WORDS   (1)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_refresh    (i_refresh),
    .i_auto_en    (i_auto_en),
    .m_axis       (axis_if),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_w [FW];

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr_pix(input logic [2:0] addr, input logic [31:0] data);
    i_wr_en   = 1'b1;
    i_wr_addr = addr;
    i_wr_data = data;
    step();
    i_wr_en   = 1'b0;
  endtask

  task automatic start_frame();
    i_refresh = 1'b1;
    step();
    i_refresh = 1'b0;
    chk("latency_tvalid", 32'(axis_if.m_axis_tvalid), 32'd1);
    chk("start_word", axis_if.m_axis_data, 32'h0000_0000);
    chk("busy_start", 32'(o_busy), 32'd1);
  endtask

  // Consume one frame; optionally random tready, a mid-frame write and refresh pulses.
  task automatic run_frame(input bit rnd, input int wr_at, input int rf_a, input int rf_b);
    int          got     = 0;
    int          cyc     = 0;
    bit          stalled = 1'b0;
    logic        ready;
    logic [31:0] prev    = '0;
    while (got < FW && cyc < 400) begin
      if (stalled) begin
        chk("stall_tvalid", 32'(axis_if.m_axis_tvalid), 32'd1);
        chk("stall_data", axis_if.m_axis_data, prev);
      end
      i_wr_en   = (cyc == wr_at);
      i_refresh = (cyc == rf_a) || (cyc == rf_b);
      ready     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      axis_if.m_axis_tready = ready;
      stalled = 1'b0;
      if (axis_if.m_axis_tvalid) begin
        if (ready) begin
          chk($sformatf("word%0d", got), axis_if.m_axis_data, exp_w[got]);
          got++;
        end else begin
          stalled = 1'b1;
          prev    = axis_if.m_axis_data;
        end
      end
      step();
      cyc++;
    end
    i_wr_en   = 1'b0;
    i_refresh = 1'b0;
    axis_if.m_axis_tready = 1'b1;
    if (got < FW) chk("frame_timeout", 32'(got), 32'(FW));
    chk("done_pulse", 32'(o_frame_done), 32'd1);
    chk("tvalid_drop", 32'(axis_if.m_axis_tvalid), 32'd0);
    chk("busy_drop", 32'(o_busy), 32'd0);
  endtask

  task automatic after_frame();
    step();
    chk("done_one_cycle", 32'(o_frame_done), 32'd0);
    chk("idle_tvalid", 32'(axis_if.m_axis_tvalid), 32'd0);
  endtask

  initial begin
    int seen;
    int nrise;
    int next_at;
    logic prev_tv;

    i_reset_n = 1'b0;
    i_wr_en   = 1'b0;
    i_wr_addr = '0;
    i_wr_data = '0;
    i_refresh = 1'b0;
    i_auto_en = 1'b0;
    axis_if.m_axis_tready = 1'b1;
    repeat (3) step();
    chk("rst_tvalid", 32'(axis_if.m_axis_tvalid), 32'd0);
    chk("rst_data", axis_if.m_axis_data, 32'h0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_frame_done), 32'd0);
    i_reset_n = 1'b1;
    step();

    // Frame 1: only pixel0 lit.
    wr_pix(3'd0, 32'h1F00_00FF);
    exp_w[0] = 32'h0000_0000;
    exp_w[1] = 32'hFF00_00FF;
    for (int i = 2; i < 9; i++) exp_w[i] = 32'hE000_0000;
    exp_w[9] = 32'hFFFF_FFFF;
    start_frame();
    run_frame(1'b0, -1, -1, -1);
    after_frame();

    // Random backpressure yields the same sequence.
    start_frame();
    run_frame(1'b1, -1, -1, -1);
    after_frame();

    // Pixel3 written mid-frame only shows up in the following frame.
    i_wr_addr = 3'd3;
    i_wr_data = 32'h0A12_3456;
    start_frame();
    run_frame(1'b0, 3, -1, -1);
    after_frame();
    exp_w[4] = 32'hEA12_3456;
    start_frame();
    run_frame(1'b0, -1, -1, -1);
    after_frame();

    // Two refreshes while busy coalesce into one back-to-back frame.
    start_frame();
    run_frame(1'b0, -1, 2, 5);
    step();
    chk("b2b_tvalid", 32'(axis_if.m_axis_tvalid), 32'd1);
    chk("b2b_start", axis_if.m_axis_data, 32'h0000_0000);
    run_frame(1'b0, -1, -1, -1);
    seen = 0;
    repeat (20) begin
      step();
      if (axis_if.m_axis_tvalid) seen++;
    end
    chk("no_extra_frame", 32'(seen), 32'd0);

    // Auto refresh every 100 cycles.
    i_auto_en = 1'b1;
    nrise     = 0;
    next_at   = 100;
    prev_tv   = 1'b0;
    for (int c = 1; c <= 350; c++) begin
      step();
      if (axis_if.m_axis_tvalid && !prev_tv) begin
        chk("auto_period", 32'(c), 32'(next_at));
        next_at += 100;
        nrise++;
      end
      prev_tv = axis_if.m_axis_tvalid;
    end
    chk("auto_count", 32'(nrise), 32'd3);
    i_auto_en = 1'b0;
    seen = 0;
    repeat (300) begin
      step();
      if (axis_if.m_axis_tvalid) seen++;
    end
    chk("auto_off", 32'(seen), 32'd0);

    // Reset while sending pixel4 aborts the frame and clears the banks.
    start_frame();
    repeat (5) step();
    chk("pre_reset_busy", 32'(o_busy), 32'd1);
    chk("pre_reset_pix4", axis_if.m_axis_data, 32'hE000_0000);
    i_reset_n = 1'b0;
    #1;
    chk("abort_tvalid", 32'(axis_if.m_axis_tvalid), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_data", axis_if.m_axis_data, 32'h0);
    step();
    chk("abort_no_done", 32'(o_frame_done), 32'd0);
    step();
    i_reset_n = 1'b1;
    step();
    chk("post_rst_done", 32'(o_frame_done), 32'd0);
    chk("post_rst_tvalid", 32'(axis_if.m_axis_tvalid), 32'd0);
    exp_w[1] = 32'hE000_0000;
    exp_w[4] = 32'hE000_0000;
    start_frame();
    run_frame(1'b0, -1, -1, -1);
    after_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
